// File: rtl/load_queue.sv
// Load queue: DEPTH in-flight loads, oldest-first issue by age rank, ROB writeback on response.
// Optional performance counters are compiled in with `define LQ_PERF_EN.
module load_queue #(
    parameter int DEPTH  = 4,
    parameter int ROB_IX = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         flush_in,
    input  logic                         valid_input_in,
    input  logic [ADDR_W-1:0]            dest_in,
    input  logic [ROB_IX:0]              rob_ix_in,
    output logic                         ready_out,
    input  logic [DEPTH-1:0]             can_load_in,
    output logic [ADDR_W*DEPTH-1:0]      lb_dest_out,
    output logic [(ROB_IX+1)*DEPTH-1:0]  lb_rob_arr_ix_out,
    output logic [DEPTH-1:0]             lb_wait_out,
    output logic                         valid_out,
    input  logic                         read_in,
    output logic [ADDR_W-1:0]            dest_out,
    output logic [ROB_IX:0]              rob_ix_out,
    input  logic                         resp_valid_in,
    input  logic [ROB_IX:0]              resp_rob_ix_in,
    input  logic [DATA_W-1:0]            resp_data_in,
    output logic                         wb_valid_out,
    output logic [ROB_IX:0]              wb_rob_ix_out,
    output logic [DATA_W-1:0]            wb_data_out
`ifdef LQ_PERF_EN
    ,
    output logic [31:0]                  perf_issue_cnt_out,
    output logic [31:0]                  perf_full_cnt_out
`endif
);

    localparam int IXW = $clog2(DEPTH);
    localparam int RW  = ROB_IX + 1;
    localparam logic [IXW:0] RANK_ONE = 1;

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ISSUED = 2'd2
    } ent_st_e;

    ent_st_e           st_q   [DEPTH];
    ent_st_e           st_d   [DEPTH];
    logic [IXW:0]      rank_q [DEPTH];
    logic [IXW:0]      rank_d [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [RW-1:0]     rob_q  [DEPTH];
    logic [RW-1:0]     rob_d  [DEPTH];

    logic              wb_valid_q, wb_valid_d;
    logic [RW-1:0]     wb_rob_q, wb_rob_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    logic [IXW-1:0]    alloc_ix;
    logic              pick_valid;
    logic [IXW-1:0]    pick_ix;
    logic [IXW:0]      pick_rank;
    logic [DEPTH-1:0]  pick_oh;
    logic [DEPTH-1:0]  resp_hit;
    logic [IXW:0]      live_cnt;
    logic [IXW:0]      freed_cnt;
    logic [IXW:0]      dec      [DEPTH];
    logic              alloc_fire;
    logic              issue_fire;

    // Lowest-index FREE slot, judged on pre-edge state only.
    always_comb begin
        ready_out = 1'b0;
        alloc_ix  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (st_q[i] == ST_FREE && !ready_out) begin
                ready_out = 1'b1;
                alloc_ix  = IXW'(i);
            end
        end
    end

    always_comb begin
        pick_valid = 1'b0;
        pick_ix    = '0;
        pick_rank  = '0;
        pick_oh    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (st_q[i] == ST_WAIT && can_load_in[i] &&
                (!pick_valid || rank_q[i] < pick_rank)) begin
                pick_valid = 1'b1;
                pick_ix    = IXW'(i);
                pick_rank  = rank_q[i];
            end
        end
        if (pick_valid) pick_oh[pick_ix] = 1'b1;
        valid_out  = pick_valid;
        dest_out   = pick_valid ? addr_q[pick_ix] : '0;
        rob_ix_out = pick_valid ? rob_q[pick_ix]  : '0;
    end

    always_comb begin
        lb_dest_out       = '0;
        lb_rob_arr_ix_out = '0;
        lb_wait_out       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            lb_dest_out[i*ADDR_W +: ADDR_W]   = addr_q[i];
            lb_rob_arr_ix_out[i*RW +: RW]     = rob_q[i];
            lb_wait_out[i]                    = (st_q[i] == ST_WAIT);
        end
    end

    // Responses and rank compaction: each survivor moves down by the number of freed entries older than it.
    always_comb begin
        live_cnt  = '0;
        freed_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            resp_hit[i] = resp_valid_in && st_q[i] == ST_ISSUED && rob_q[i] == resp_rob_ix_in;
            if (st_q[i] != ST_FREE) live_cnt = live_cnt + RANK_ONE;
            if (resp_hit[i]) freed_cnt = freed_cnt + RANK_ONE;
        end
        for (int i = 0; i < DEPTH; i++) begin
            dec[i] = '0;
            for (int j = 0; j < DEPTH; j++) begin
                if (resp_hit[j] && rank_q[j] < rank_q[i]) dec[i] = dec[i] + RANK_ONE;
            end
        end
    end

    assign alloc_fire = valid_input_in && ready_out;
    assign issue_fire = pick_valid && read_in;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            st_d[i]   = st_q[i];
            rank_d[i] = rank_q[i];
            addr_d[i] = addr_q[i];
            rob_d[i]  = rob_q[i];
            if (resp_hit[i]) begin
                st_d[i]   = ST_FREE;
                rank_d[i] = '0;
            end else if (st_q[i] != ST_FREE) begin
                rank_d[i] = rank_q[i] - dec[i];
                if (issue_fire && pick_oh[i]) st_d[i] = ST_ISSUED;
            end
        end
        if (alloc_fire) begin
            st_d[alloc_ix]   = ST_WAIT;
            rank_d[alloc_ix] = live_cnt - freed_cnt;
            addr_d[alloc_ix] = dest_in;
            rob_d[alloc_ix]  = rob_ix_in;
        end
        if (flush_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                st_d[i]   = ST_FREE;
                rank_d[i] = '0;
            end
        end

        wb_valid_d = (|resp_hit) && !flush_in;
        wb_rob_d   = wb_rob_q;
        wb_data_d  = wb_data_q;
        if (wb_valid_d) begin
            wb_rob_d  = resp_rob_ix_in;
            wb_data_d = resp_data_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                st_q[i]   <= ST_FREE;
                rank_q[i] <= '0;
                addr_q[i] <= '0;
                rob_q[i]  <= '0;
            end
            wb_valid_q <= 1'b0;
            wb_rob_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                st_q[i]   <= st_d[i];
                rank_q[i] <= rank_d[i];
                addr_q[i] <= addr_d[i];
                rob_q[i]  <= rob_d[i];
            end
            wb_valid_q <= wb_valid_d;
            wb_rob_q   <= wb_rob_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign wb_valid_out  = wb_valid_q;
    assign wb_rob_ix_out = wb_rob_q;
    assign wb_data_out   = wb_data_q;

`ifdef LQ_PERF_EN
    logic [31:0] perf_issue_cnt_q, perf_issue_cnt_d;
    logic [31:0] perf_full_cnt_q, perf_full_cnt_d;

    // Saturating; flush deliberately leaves these alone.
    always_comb begin
        perf_issue_cnt_d = perf_issue_cnt_q;
        perf_full_cnt_d  = perf_full_cnt_q;
        if (issue_fire && perf_issue_cnt_q != '1) perf_issue_cnt_d = perf_issue_cnt_q + 32'd1;
        if (valid_input_in && !ready_out && perf_full_cnt_q != '1)
            perf_full_cnt_d = perf_full_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            perf_issue_cnt_q <= '0;
            perf_full_cnt_q  <= '0;
        end else begin
            perf_issue_cnt_q <= perf_issue_cnt_d;
            perf_full_cnt_q  <= perf_full_cnt_d;
        end
    end

    assign perf_issue_cnt_out = perf_issue_cnt_q;
    assign perf_full_cnt_out  = perf_full_cnt_q;
`endif

endmodule

// File: tb/tb_load_queue.sv
// Bench for load_queue: age-list reference model, writeback scoreboard and monitor.
module tb_load_queue;

    localparam int DEPTH  = 4;
    localparam int ROB_IX = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int RW     = ROB_IX + 1;

    logic                    clk = 1'b0;
    logic                    rst_in;
    logic                    flush_in;
    logic                    valid_input_in;
    logic [ADDR_W-1:0]       dest_in;
    logic [RW-1:0]           rob_ix_in;
    logic                    ready_out;
    logic [DEPTH-1:0]        can_load_in;
    logic [ADDR_W*DEPTH-1:0] lb_dest_out;
    logic [RW*DEPTH-1:0]     lb_rob_arr_ix_out;
    logic [DEPTH-1:0]        lb_wait_out;
    logic                    valid_out;
    logic                    read_in;
    logic [ADDR_W-1:0]       dest_out;
    logic [RW-1:0]           rob_ix_out;
    logic                    resp_valid_in;
    logic [RW-1:0]           resp_rob_ix_in;
    logic [DATA_W-1:0]       resp_data_in;
    logic                    wb_valid_out;
    logic [RW-1:0]           wb_rob_ix_out;
    logic [DATA_W-1:0]       wb_data_out;
`ifdef LQ_PERF_EN
    logic [31:0]             perf_issue_cnt_out;
    logic [31:0]             perf_full_cnt_out;
`endif

    load_queue #(.DEPTH(DEPTH), .ROB_IX(ROB_IX), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_in(clk), .rst_in(rst_in), .flush_in(flush_in),
        .valid_input_in(valid_input_in), .dest_in(dest_in), .rob_ix_in(rob_ix_in),
        .ready_out(ready_out), .can_load_in(can_load_in),
        .lb_dest_out(lb_dest_out), .lb_rob_arr_ix_out(lb_rob_arr_ix_out),
        .lb_wait_out(lb_wait_out), .valid_out(valid_out), .read_in(read_in),
        .dest_out(dest_out), .rob_ix_out(rob_ix_out),
        .resp_valid_in(resp_valid_in), .resp_rob_ix_in(resp_rob_ix_in),
        .resp_data_in(resp_data_in), .wb_valid_out(wb_valid_out),
        .wb_rob_ix_out(wb_rob_ix_out), .wb_data_out(wb_data_out)
`ifdef LQ_PERF_EN
        , .perf_issue_cnt_out(perf_issue_cnt_out), .perf_full_cnt_out(perf_full_cnt_out)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic mon_en = 1'b0;

    // Reference model: entry states (0 free, 1 wait, 2 issued) plus an age-ordered list.
    int                m_st   [DEPTH];
    logic [ADDR_W-1:0] m_addr [DEPTH];
    logic [RW-1:0]     m_rob  [DEPTH];
    int                age_q[$];
    int                m_issue_cnt = 0;
    int                m_full_cnt  = 0;

    logic [RW+DATA_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard monitor: a writeback is due exactly one cycle after its response.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("wb_valid", 64'(wb_valid_out), 64'(exp_q.size() != 0));
                if (exp_q.size() != 0) begin
                    logic [RW+DATA_W-1:0] e;
                    e = exp_q.pop_front();
                    if (wb_valid_out) begin
                        chk("wb_rob_ix", 64'(wb_rob_ix_out), 64'(e[RW+DATA_W-1:DATA_W]));
                        chk("wb_data", 64'(wb_data_out), 64'(e[DATA_W-1:0]));
                    end
                end
            end
        end
    end

    // Driver: one cycle of stimulus, check of combinational outputs, then model advance.
    task automatic step(input logic f, input logic vin, input logic [ADDR_W-1:0] a,
                        input logic [RW-1:0] r, input logic [DEPTH-1:0] cl, input logic rd,
                        input logic rv, input logic [RW-1:0] rr, input logic [DATA_W-1:0] rdat);
        int alloc_ix, pick, hit;
        logic exp_ready;
        logic [DEPTH-1:0] exp_wait;
        @(negedge clk);
        flush_in = f; valid_input_in = vin; dest_in = a; rob_ix_in = r;
        can_load_in = cl; read_in = rd; resp_valid_in = rv;
        resp_rob_ix_in = rr; resp_data_in = rdat;
        #1;
        alloc_ix = -1;
        exp_wait = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_st[i] == 0 && alloc_ix < 0) alloc_ix = i;
            exp_wait[i] = (m_st[i] == 1);
        end
        exp_ready = (alloc_ix >= 0);
        pick = -1;
        foreach (age_q[k]) if (pick < 0 && m_st[age_q[k]] == 1 && cl[age_q[k]]) pick = age_q[k];

        chk("ready_out", 64'(ready_out), 64'(exp_ready));
        chk("valid_out", 64'(valid_out), 64'(pick >= 0));
        chk("dest_out", 64'(dest_out), (pick >= 0) ? 64'(m_addr[pick]) : 64'd0);
        chk("rob_ix_out", 64'(rob_ix_out), (pick >= 0) ? 64'(m_rob[pick]) : 64'd0);
        chk("lb_wait_out", 64'(lb_wait_out), 64'(exp_wait));
        for (int i = 0; i < DEPTH; i++) begin
            if (m_st[i] != 0) begin
                chk("lb_dest", 64'(lb_dest_out[i*ADDR_W +: ADDR_W]), 64'(m_addr[i]));
                chk("lb_rob", 64'(lb_rob_arr_ix_out[i*RW +: RW]), 64'(m_rob[i]));
            end
        end

        if (pick >= 0 && rd) m_issue_cnt++;
        if (vin && !exp_ready) m_full_cnt++;
        if (f) begin
            for (int i = 0; i < DEPTH; i++) m_st[i] = 0;
            age_q.delete();
        end else begin
            hit = -1;
            if (rv) for (int i = 0; i < DEPTH; i++) if (m_st[i] == 2 && m_rob[i] == rr) hit = i;
            if (hit >= 0) begin
                m_st[hit] = 0;
                foreach (age_q[k]) if (age_q[k] == hit) begin age_q.delete(k); break; end
                exp_q.push_back({rr, rdat});
            end
            if (pick >= 0 && rd) m_st[pick] = 2;
            if (vin && exp_ready) begin
                m_st[alloc_ix]   = 1;
                m_addr[alloc_ix] = a;
                m_rob[alloc_ix]  = r;
                age_q.push_back(alloc_ix);
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    function automatic logic [RW-1:0] free_rob();
        logic [RW-1:0] r;
        logic used;
        for (int t = 0; t < 64; t++) begin
            r = RW'($urandom_range(0, (1 << RW) - 1));
            used = 1'b0;
            for (int i = 0; i < DEPTH; i++) if (m_st[i] != 0 && m_rob[i] == r) used = 1'b1;
            if (!used) return r;
        end
        for (int v = 0; v < (1 << RW); v++) begin
            used = 1'b0;
            for (int i = 0; i < DEPTH; i++) if (m_st[i] != 0 && m_rob[i] == RW'(v)) used = 1'b1;
            if (!used) return RW'(v);
        end
        return '0;
    endfunction

    initial begin
        rst_in = 1'b1; flush_in = 1'b0; valid_input_in = 1'b0; dest_in = '0; rob_ix_in = '0;
        can_load_in = '0; read_in = 1'b0; resp_valid_in = 1'b0; resp_rob_ix_in = '0;
        resp_data_in = '0;
        for (int i = 0; i < DEPTH; i++) begin m_st[i] = 0; m_addr[i] = '0; m_rob[i] = '0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wb_valid", 64'(wb_valid_out), 64'd0);
        chk("rst_wb_rob", 64'(wb_rob_ix_out), 64'd0);
        chk("rst_wb_data", 64'(wb_data_out), 64'd0);
        chk("rst_lb_dest", 64'(lb_dest_out[63:0]), 64'd0);
        chk("rst_lb_rob", 64'(lb_rob_arr_ix_out), 64'd0);
        chk("rst_ready", 64'(ready_out), 64'd1);
        chk("rst_valid", 64'(valid_out), 64'd0);
        chk("rst_dest", 64'(dest_out), 64'd0);
        rst_in = 1'b0;
        mon_en = 1'b1;

        // Single load: allocate, issue, respond.
        step(1'b0, 1'b1, 32'h100, 3'd5, 4'b0001, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, '0, 4'b0001, 1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, '0, 4'b0001, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 3'd5, 32'h1234);
        idle();

        // Age ordering: entry1 is older than entry2.
        step(1'b0, 1'b1, 32'h200, 3'd1, '0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 32'h204, 3'd2, '0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 32'h208, 3'd3, '0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, '0, 4'b0110, 1'b1, 1'b0, '0, '0);

        // Fill, drop a fifth request, then free entry0 and watch the ranks compact.
        step(1'b0, 1'b1, 32'h20c, 3'd4, '0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 32'h210, 3'd7, '0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, '0, 4'b0001, 1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b1, 32'h214, 3'd7, '0, 1'b0, 1'b1, 3'd1, 32'hDEAD);
        step(1'b0, 1'b0, '0, '0, 4'b1100, 1'b0, 1'b0, '0, '0);

        // Same-cycle allocate, issue (entry2) and response (entry1).
        step(1'b0, 1'b1, 32'h300, 3'd6, 4'b0100, 1'b1, 1'b1, 3'd2, 32'hBEEF);
        step(1'b0, 1'b0, '0, '0, 4'b1111, 1'b0, 1'b0, '0, '0);

        // Flush with a live response on the same cycle.
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b1, 3'd3, 32'hF00D);
        step(1'b0, 1'b0, '0, '0, 4'b1111, 1'b1, 1'b0, '0, '0);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            logic f, vin, rd, rv;
            logic [RW-1:0] rr;
            int iss[$];
            f   = ($urandom_range(0, 49) == 0);
            vin = ($urandom_range(0, 2) != 0);
            rd  = ($urandom_range(0, 1) != 0);
            rv  = ($urandom_range(0, 2) != 0);
            iss.delete();
            for (int i = 0; i < DEPTH; i++) if (m_st[i] == 2) iss.push_back(i);
            if (iss.size() != 0 && $urandom_range(0, 3) != 0)
                rr = m_rob[iss[$urandom_range(0, iss.size() - 1)]];
            else
                rr = RW'($urandom_range(0, (1 << RW) - 1));
            step(f, vin, ADDR_W'($urandom), free_rob(), DEPTH'($urandom), rd, rv, rr,
                 DATA_W'($urandom));
        end

        repeat (3) idle();
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
`ifdef LQ_PERF_EN
        chk("perf_issue", 64'(perf_issue_cnt_out), 64'(m_issue_cnt));
        chk("perf_full", 64'(perf_full_cnt_out), 64'(m_full_cnt));
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
